ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the EX-stage operands and funct3 of an M-extension instruction and raises a stall request to the hazard unit until the result is ready.
- Presents a 32-bit result to the EX result mux for one completion cycle, which is then captured by EX/MEM.
- One operation is in flight at a time; there is no internal queue.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  reset, asynchronous and active-low.
- muldiv_valid_ex  input  1  the EX-stage instruction is an M-extension op (OP opcode, funct7=0000001).
- instr_funct3_ex  input  3  M operation select.
- rs1_data_ex  input  32  forwarded operand A.
- rs2_data_ex  input  32  forwarded operand B.
- hold_ex  input  1  the EX/MEM register is stalled this cycle, so a completed result may not leave.
- flush_ex  input  1  kill the EX-stage instruction (trap/redirect).
- stall_req  output  1  to the hazard unit: stall IF/ID/EX and bubble EX/MEM.
- result_valid  output  1  result holds the completed value this cycle.
- result  output  32  M-op result.
- busy  output  1  FSM is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, and all datapath registers=0.
  - result=0, result_valid=0, busy=0, stall_req forced to 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If muldiv_valid_ex and not flush_ex, latch the operands, funct3 and sign info; stall_req=1 combinationally in this same cycle.
  - Next state is BUSY with counter=31.
  - If FAST_SPECIAL=1 and the op is a division special case, next state is DONE with the result preloaded.
- BUSY:
  - One iteration per cycle; counter decrements; stall_req=1.
  - When counter=0 at a clock edge, next state is DONE.
- DONE:
  - result_valid=1, stall_req=0, so the pipeline advances and EX/MEM captures result.
  - If hold_ex=1, remain in DONE with the result stable.
  - Otherwise go to IDLE.
- Latency (instruction entering EX at cycle 0, no hold):
  - Cycles 1..32 are BUSY and cycle 33 is DONE: 34 EX cycles total.
  - A special case is DONE at cycle 1.
- Back-to-back ops: after DONE, the next M-op reaches EX and is accepted in IDLE on the following cycle. There is no zero-bubble chaining.
- flush_ex:
  - Overrides everything: stall_req=0 in the same cycle and next state is IDLE.
  - The partial result is discarded and result_valid is not raised.
- Multiply:
  - Shift-add on the 32-bit magnitudes producing a 64-bit product, then two's-complement negation if the sign fix is needed.
  - MUL returns the low 32 bits.
  - MULH treats both operands as signed; MULHSU treats rs1 as signed and rs2 as unsigned; MULHU treats both as unsigned.
  - The MULH variants return the high 32 bits.
- Divide:
  - Restoring division on magnitudes with a 33-bit partial remainder.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A); signed ops only.
- RISC-V special cases (also correct when FAST_SPECIAL=0, via the final fix-up):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give A.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Operands are sampled only in IDLE; later changes on rs*_data_ex while busy are ignored.
- muldiv_valid_ex dropping while BUSY without flush_ex is illegal. The bench flags it as an assertion error; no RTL recovery is required.

Decomposition:
- defines.v gains:
  - funct3 constants MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
  - The funct7 M-extension constant 0000001.
  - FSM state encodings IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module, muldiv_iter_datapath: the per-cycle shift-add / restore-subtract step plus the sign fix-up. ex_muldiv_unit keeps the FSM, counter, handshake and special-case detection.

Test Plan:
- Reset asserted mid-BUSY (cycle 10) -> all outputs 0 immediately. After release, the FSM is IDLE and a new MUL 3*4 returns 12.
- MUL 0xFFFFFFFF*0x00000002 -> stall_req high for 33 cycles (0..32), result_valid in cycle 33, result=0xFFFFFFFE. With the same operands, MULH gives 0xFFFFFFFF and MULHU gives 0x00000001.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM gives 0xFFFFFFFF; DIVU 7/2 gives 3; REMU gives 1.
- DIVU 5/0 -> 0xFFFFFFFF, with result_valid at cycle 1 when FAST_SPECIAL=1. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM gives 0.
- hold_ex=1 for 3 cycles while in DONE -> result_valid and result stay stable for 4 cycles, stall_req=0, then IDLE.
- flush_ex at BUSY cycle 5 -> stall_req=0 the same cycle, no result_valid, IDLE next. A following MULHSU 0xFFFFFFFF*0xFFFFFFFF returns 0xFFFFFFFF.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants and types for the iterative RV32M multiply/divide unit.
// Funct3 and funct7 encodings, FSM state encoding and a sign/magnitude helper.
package ex_muldiv_unit_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_e;

  // Two's-complement negate when neg is set; used both for magnitudes and sign fix-up.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_datapath.sv
// Iteration datapath: one shift-add (multiply) or restoring-subtract (divide)
// step per cycle on operand magnitudes, plus the final sign fix-up.
module muldiv_iter_datapath
  import ex_muldiv_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result
);

  // acc holds {hi, lo} of the product, or {remainder, dividend/quotient}.
  logic [63:0] acc_q;
  logic [31:0] opb_q;
  logic [2:0]  funct3_q;
  logic        neg_main_q;
  logic        neg_rem_q;

  logic        signed_a, signed_b, sign_a, sign_b;
  logic [32:0] mul_sum, div_shift, div_diff;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  always_comb begin
    signed_a = funct3[2] ? ~funct3[0] : (funct3 == F3_MULH || funct3 == F3_MULHSU);
    signed_b = funct3[2] ? ~funct3[0] : (funct3 == F3_MULH);
    sign_a   = op_a[31] & signed_a;
    sign_b   = op_b[31] & signed_b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = acc_q[63:31];
    div_diff  = div_shift - {1'b0, opb_q};
    if (!funct3_q[2])
      acc_step = {mul_sum, acc_q[31:1]};
    else if (!div_diff[32])
      acc_step = {div_diff[31:0], acc_q[30:0], 1'b1};
    else
      acc_step = {div_shift[31:0], acc_q[30:0], 1'b0};
  end

  always_comb begin
    prod_fix = neg_main_q ? (~acc_q + 64'd1) : acc_q;
    quo_fix  = neg32(acc_q[31:0], neg_main_q);
    rem_fix  = neg32(acc_q[63:32], neg_rem_q);
    case (funct3_q)
      F3_MUL:                       result = prod_fix[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[63:32];
      F3_DIV, F3_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q      <= '0;
      opb_q      <= '0;
      funct3_q   <= '0;
      neg_main_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (load) begin
      acc_q      <= {32'd0, neg32(op_a, sign_a)};
      opb_q      <= neg32(op_b, sign_b);
      funct3_q   <= funct3;
      // A zero divisor leaves an all-ones quotient that must not be negated.
      neg_main_q <= funct3[2] ? ((sign_a ^ sign_b) & (op_b != 32'd0)) : (sign_a ^ sign_b);
      neg_rem_q  <= sign_a;
    end else if (step) begin
      acc_q <= acc_step;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative RV32M unit: FSM, iteration counter, pipeline stall/hold
// handshake and fast completion of divide special cases.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            muldiv_valid_ex,
  input  logic [2:0]      instr_funct3_ex,
  input  logic [XLEN-1:0] rs1_data_ex,
  input  logic [XLEN-1:0] rs2_data_ex,
  input  logic            hold_ex,
  input  logic            flush_ex,
  output logic            stall_req,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      state_dbg
);

  // Handshake: stall_req is high while an accepted op has no result yet; in
  // DONE result_valid is high and the result leaves when hold_ex is low.
  md_state_e   state_q, state_next;
  logic [4:0]  cnt_q, cnt_next;
  logic        spec_q, spec_next;
  logic [31:0] spec_val_q, spec_val_next, spec_val;
  logic        special, div_zero, div_ovf;
  logic        dp_load, dp_step, stall_int;
  logic [31:0] dp_result;

  muldiv_iter_datapath u_dp (
    .clk    (clk),
    .rst    (rst),
    .load   (dp_load),
    .step   (dp_step),
    .funct3 (instr_funct3_ex),
    .op_a   (rs1_data_ex),
    .op_b   (rs2_data_ex),
    .result (dp_result)
  );

  always_comb begin
    div_zero = (rs2_data_ex == 32'd0);
    div_ovf  = ~instr_funct3_ex[0] && (rs1_data_ex == 32'h8000_0000) &&
               (rs2_data_ex == 32'hFFFF_FFFF);
    special  = FAST_SPECIAL && instr_funct3_ex[2] && (div_zero || div_ovf);
    if (div_zero) spec_val = instr_funct3_ex[1] ? rs1_data_ex : 32'hFFFF_FFFF;
    else          spec_val = instr_funct3_ex[1] ? 32'd0 : 32'h8000_0000;
  end

  always_comb begin
    state_next    = state_q;
    cnt_next      = cnt_q;
    spec_next     = spec_q;
    spec_val_next = spec_val_q;
    stall_int     = 1'b0;
    result_valid  = 1'b0;
    dp_load       = 1'b0;
    dp_step       = 1'b0;
    case (state_q)
      IDLE: begin
        if (muldiv_valid_ex && !flush_ex) begin
          stall_int     = 1'b1;
          dp_load       = 1'b1;
          spec_next     = special;
          spec_val_next = spec_val;
          if (special) begin
            state_next = DONE;
          end else begin
            state_next = BUSY;
            cnt_next   = 5'd31;
          end
        end
      end
      BUSY: begin
        if (flush_ex) begin
          state_next = IDLE;
        end else begin
          stall_int = 1'b1;
          dp_step   = 1'b1;
          cnt_next  = cnt_q - 5'd1;
          if (cnt_q == 5'd0) state_next = DONE;
        end
      end
      DONE: begin
        if (flush_ex) begin
          state_next = IDLE;
        end else begin
          result_valid = 1'b1;
          if (!hold_ex) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
    end else begin
      state_q    <= state_next;
      cnt_q      <= cnt_next;
      spec_q     <= spec_next;
      spec_val_q <= spec_val_next;
    end
  end

  // Reset is asynchronous, so the combinational stall is masked by it directly.
  assign stall_req = stall_int & rst;
  assign result    = (state_q == DONE) ? (spec_q ? spec_val_q : dp_result) : '0;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed vector table, reset/hold/flush sequences
// and random ops checked against an arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam bit FAST = 1'b1;

  logic        clk = 1'b0;
  logic        rst;
  logic        muldiv_valid_ex;
  logic [2:0]  instr_funct3_ex;
  logic [31:0] rs1_data_ex, rs2_data_ex;
  logic        hold_ex, flush_ex;
  logic        stall_req, result_valid, busy;
  logic [31:0] result;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[14];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(FAST)) dut (
    .clk             (clk),
    .rst             (rst),
    .muldiv_valid_ex (muldiv_valid_ex),
    .instr_funct3_ex (instr_funct3_ex),
    .rs1_data_ex     (rs1_data_ex),
    .rs2_data_ex     (rs2_data_ex),
    .hold_ex         (hold_ex),
    .flush_ex        (flush_ex),
    .stall_req       (stall_req),
    .result_valid    (result_valid),
    .result          (result),
    .busy            (busy),
    .state_dbg       (state_dbg)
  );

  always @(negedge clk) begin
    if (rst && state_dbg == 2'd1 && !flush_ex)
      assert (muldiv_valid_ex) else $error("muldiv_valid_ex dropped while busy");
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, want test completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] ua, ub, p;
    int ia, ib;
    logic ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    ub_s = ub;
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub;   return p[31:0];  end
      3'd1: begin p = sa * sb;   return p[63:32]; end
      3'd2: begin p = sa * ub_s; return p[63:32]; end
      3'd3: begin p = ua * ub;   return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // ---------------- driver ----------------
  // Entered at a negedge with the unit idle; returns at a negedge, idle again.
  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int hold_n);
    int lat;
    int exp_lat;
    logic stall_ok;
    logic [31:0] got;
    exp_lat = (FAST && is_special(f3, a, b)) ? 1 : 33;
    muldiv_valid_ex = 1'b1;
    instr_funct3_ex = f3;
    rs1_data_ex     = a;
    rs2_data_ex     = b;
    #1;
    check({name, " stall_c0"}, stall_req, 1);
    lat = 0;
    stall_ok = 1'b1;
    forever begin
      @(negedge clk);
      lat++;
      if (result_valid || lat >= 100) break;
      if (stall_req !== 1'b1) stall_ok = 1'b0;
      rs1_data_ex = $urandom;
      rs2_data_ex = $urandom;
    end
    check({name, " latency"}, lat, exp_lat);
    check({name, " stall_busy"}, stall_ok, 1);
    got = result;
    check({name, " result"}, got, exp_q.pop_front());
    for (int i = 0; i <= hold_n; i++) begin
      if (i > 0) begin
        @(negedge clk);
        check({name, " held_result"}, result, got);
      end
      check({name, " valid"}, result_valid, 1);
      check({name, " stall_done"}, stall_req, 0);
      hold_ex = (i < hold_n);
    end
    muldiv_valid_ex = 1'b0;
    @(negedge clk);
    check({name, " idle"}, busy, 0);
    check({name, " valid_off"}, result_valid, 0);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;

    vecs[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
    vecs[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001};
    vecs[3]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    vecs[4]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[5]  = '{3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003};
    vecs[6]  = '{3'd7, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001};
    vecs[7]  = '{3'd5, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[8]  = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[10] = '{3'd7, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    vecs[11] = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
    vecs[12] = '{3'd4, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[13] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

    rst = 1'b0;
    muldiv_valid_ex = 1'b0;
    instr_funct3_ex = '0;
    rs1_data_ex = '0;
    rs2_data_ex = '0;
    hold_ex = 1'b0;
    flush_ex = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("reset stall", stall_req, 0);
    check("reset valid", result_valid, 0);
    check("reset busy", busy, 0);
    check("reset result", result, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(vecs[i].exp);
      do_op($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, 0);
    end

    // reset asserted in the middle of an iteration
    muldiv_valid_ex = 1'b1;
    instr_funct3_ex = 3'd0;
    rs1_data_ex = 32'd7;
    rs2_data_ex = 32'd9;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst stall", stall_req, 0);
    check("midrst valid", result_valid, 0);
    check("midrst busy", busy, 0);
    check("midrst result", result, 0);
    muldiv_valid_ex = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("postrst busy", busy, 0);
    exp_q.push_back(32'd12);
    do_op("postrst_mul", 3'd0, 32'd3, 32'd4, 0);

    // hold_ex keeps the completed result in place
    exp_q.push_back(ref_op(3'd0, 32'h0000_1234, 32'h0000_0010));
    do_op("hold", 3'd0, 32'h0000_1234, 32'h0000_0010, 3);

    // flush during BUSY cycle 5
    muldiv_valid_ex = 1'b1;
    instr_funct3_ex = 3'd1;
    rs1_data_ex = 32'h1234_5678;
    rs2_data_ex = 32'h9ABC_DEF0;
    repeat (5) @(negedge clk);
    flush_ex = 1'b1;
    #1;
    check("flush stall", stall_req, 0);
    check("flush valid", result_valid, 0);
    @(negedge clk);
    check("flush idle", busy, 0);
    check("flush no_valid", result_valid, 0);
    flush_ex = 1'b0;
    muldiv_valid_ex = 1'b0;
    @(negedge clk);
    exp_q.push_back(32'hFFFF_FFFF);
    do_op("post_flush_mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // randomized ops against the reference model
    for (int n = 0; n < 40; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      exp_q.push_back(ref_op(rf3, ra, rb));
      do_op($sformatf("rand%0d_f%0d", n, rf3), rf3, ra, rb, int'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
